// File: rtl/rat_pkg.sv
// Shared encodings for the RAT MCU control path: opcodes, sequencer states, mux selects.
package rat_pkg;

  localparam logic [6:0] OP_BRN   = 7'b0010000;
  localparam logic [6:0] OP_CALL  = 7'b0010001;
  localparam logic [6:0] OP_BREQ  = 7'b0010010;
  localparam logic [6:0] OP_BRNE  = 7'b0010011;
  localparam logic [6:0] OP_BRCS  = 7'b0010100;
  localparam logic [6:0] OP_BRCC  = 7'b0010101;
  localparam logic [6:0] OP_RET   = 7'b0110010;
  localparam logic [6:0] OP_SEI   = 7'b0110100;
  localparam logic [6:0] OP_CLI   = 7'b0110101;
  localparam logic [6:0] OP_RETID = 7'b0110110;
  localparam logic [6:0] OP_RETIE = 7'b0110111;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_INTR  = 2'd3
  } state_t;

  localparam logic [1:0] PC_SEL_IMM   = 2'd0;
  localparam logic [1:0] PC_SEL_STACK = 2'd1;
  localparam logic [1:0] PC_SEL_VEC   = 2'd2;
  localparam logic [1:0] PC_SEL_ZERO  = 2'd3;

  localparam logic [1:0] SCR_SEL_REG   = 2'd0;
  localparam logic [1:0] SCR_SEL_IMM   = 2'd1;
  localparam logic [1:0] SCR_SEL_SP    = 2'd2;
  localparam logic [1:0] SCR_SEL_SP_M1 = 2'd3;

endpackage

// File: rtl/rat_pc_sequencer.sv
// FETCH/EXEC/INTR control FSM for the RAT PC, stack and interrupt-enable flag.
// Outputs are Mealy in EXEC; only the state and I_FLAG are registered.
module rat_pc_sequencer
  import rat_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic [6:0] OPCODE,
  input  logic       C_FLAG,
  input  logic       Z_FLAG,
  input  logic       INT,
  output logic       PC_RST,
  output logic       PC_LD,
  output logic       PC_INC,
  output logic [1:0] PC_MUX_SEL,
  output logic       IR_LD,
  output logic       SP_INCR,
  output logic       SP_DECR,
  output logic       SCR_WE,
  output logic [1:0] SCR_ADDR_SEL,
  output logic       SCR_DATA_SEL,
  output logic       FLG_SHAD_LD,
  output logic       FLG_RESTORE,
  output logic       I_FLAG
);

  state_t state_q, state_d;
  logic   i_flag_q, i_flag_d;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= ST_INIT;
      i_flag_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_flag_q <= i_flag_d;
    end
  end

  assign I_FLAG = i_flag_q;

  always_comb begin
    state_d      = state_q;
    i_flag_d     = i_flag_q;
    PC_RST       = 1'b0;
    PC_LD        = 1'b0;
    PC_INC       = 1'b0;
    PC_MUX_SEL   = PC_SEL_IMM;
    IR_LD        = 1'b0;
    SP_INCR      = 1'b0;
    SP_DECR      = 1'b0;
    SCR_WE       = 1'b0;
    SCR_ADDR_SEL = SCR_SEL_REG;
    SCR_DATA_SEL = 1'b0;
    FLG_SHAD_LD  = 1'b0;
    FLG_RESTORE  = 1'b0;

    case (state_q)
      ST_INIT: begin
        PC_RST  = 1'b1;
        state_d = ST_FETCH;
      end

      ST_FETCH: begin
        IR_LD   = 1'b1;
        PC_INC  = 1'b1;
        state_d = ST_EXEC;
      end

      ST_EXEC: begin
        // Interrupt decision uses the enable value held before this instruction retires.
        state_d = (INT && i_flag_q) ? ST_INTR : ST_FETCH;
        case (OPCODE)
          OP_BRN:  PC_LD = 1'b1;
          OP_BREQ: PC_LD = Z_FLAG;
          OP_BRNE: PC_LD = ~Z_FLAG;
          OP_BRCS: PC_LD = C_FLAG;
          OP_BRCC: PC_LD = ~C_FLAG;
          OP_CALL: begin
            PC_LD        = 1'b1;
            SCR_WE       = 1'b1;
            SCR_ADDR_SEL = SCR_SEL_SP_M1;
            SCR_DATA_SEL = 1'b1;
            SP_DECR      = 1'b1;
          end
          OP_RET, OP_RETID, OP_RETIE: begin
            PC_LD        = 1'b1;
            PC_MUX_SEL   = PC_SEL_STACK;
            SCR_ADDR_SEL = SCR_SEL_SP;
            SP_INCR      = 1'b1;
            if (OPCODE != OP_RET) begin
              FLG_RESTORE = 1'b1;
              i_flag_d    = OPCODE[0];
            end
          end
          OP_SEI:  i_flag_d = 1'b1;
          OP_CLI:  i_flag_d = 1'b0;
          default: ;
        endcase
      end

      ST_INTR: begin
        PC_LD        = 1'b1;
        PC_MUX_SEL   = PC_SEL_VEC;
        SCR_WE       = 1'b1;
        SCR_ADDR_SEL = SCR_SEL_SP_M1;
        SCR_DATA_SEL = 1'b1;
        SP_DECR      = 1'b1;
        FLG_SHAD_LD  = 1'b1;
        i_flag_d     = 1'b0;
        state_d      = ST_FETCH;
      end

      default: state_d = ST_INIT;
    endcase
  end

endmodule

// File: tb/tb_rat_pc_sequencer.sv
// Directed bench for rat_pc_sequencer; every instruction task starts 2 time units after the edge that entered FETCH.
module tb_rat_pc_sequencer;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [6:0] OPCODE = 7'd0;
  logic       C_FLAG = 1'b0;
  logic       Z_FLAG = 1'b0;
  logic       INT = 1'b0;
  logic       PC_RST, PC_LD, PC_INC, IR_LD, SP_INCR, SP_DECR, SCR_WE;
  logic       SCR_DATA_SEL, FLG_SHAD_LD, FLG_RESTORE, I_FLAG;
  logic [1:0] PC_MUX_SEL, SCR_ADDR_SEL;

  int total = 0;
  int bad   = 0;

  localparam logic [6:0] NOP   = 7'b0000000;
  localparam logic [6:0] BRN   = 7'b0010000;
  localparam logic [6:0] CALL  = 7'b0010001;
  localparam logic [6:0] BREQ  = 7'b0010010;
  localparam logic [6:0] BRNE  = 7'b0010011;
  localparam logic [6:0] BRCS  = 7'b0010100;
  localparam logic [6:0] BRCC  = 7'b0010101;
  localparam logic [6:0] RET   = 7'b0110010;
  localparam logic [6:0] SEI   = 7'b0110100;
  localparam logic [6:0] CLI   = 7'b0110101;
  localparam logic [6:0] RETID = 7'b0110110;
  localparam logic [6:0] RETIE = 7'b0110111;

  always #5 CLK = ~CLK;

  rat_pc_sequencer dut (
    .CLK(CLK), .RST(RST), .OPCODE(OPCODE), .C_FLAG(C_FLAG), .Z_FLAG(Z_FLAG), .INT(INT),
    .PC_RST(PC_RST), .PC_LD(PC_LD), .PC_INC(PC_INC), .PC_MUX_SEL(PC_MUX_SEL),
    .IR_LD(IR_LD), .SP_INCR(SP_INCR), .SP_DECR(SP_DECR), .SCR_WE(SCR_WE),
    .SCR_ADDR_SEL(SCR_ADDR_SEL), .SCR_DATA_SEL(SCR_DATA_SEL),
    .FLG_SHAD_LD(FLG_SHAD_LD), .FLG_RESTORE(FLG_RESTORE), .I_FLAG(I_FLAG)
  );

  // {PC_RST,PC_LD,PC_INC,PC_MUX_SEL,IR_LD,SP_INCR,SP_DECR,SCR_WE,SCR_ADDR_SEL,SCR_DATA_SEL,FLG_SHAD_LD,FLG_RESTORE,I_FLAG}
  logic [14:0] outs;
  assign outs = {PC_RST, PC_LD, PC_INC, PC_MUX_SEL, IR_LD, SP_INCR, SP_DECR, SCR_WE,
                 SCR_ADDR_SEL, SCR_DATA_SEL, FLG_SHAD_LD, FLG_RESTORE, I_FLAG};

  function automatic logic [14:0] exp_o(input logic rst, ld, inc, input logic [1:0] sel,
                                        input logic ir, spi, spd, we, input logic [1:0] asel,
                                        input logic dsel, shad, rest, iflag);
    return {rst, ld, inc, sel, ir, spi, spd, we, asel, dsel, shad, rest, iflag};
  endfunction

  function automatic logic [14:0] e_init();
    return exp_o(1, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0);
  endfunction
  function automatic logic [14:0] e_fetch(input logic iflag);
    return exp_o(0, 0, 1, 2'd0, 1, 0, 0, 0, 2'd0, 0, 0, 0, iflag);
  endfunction
  function automatic logic [14:0] e_idle(input logic iflag);
    return exp_o(0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0, 0, 0, iflag);
  endfunction
  function automatic logic [14:0] e_br(input logic iflag);
    return exp_o(0, 1, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0, 0, 0, iflag);
  endfunction
  function automatic logic [14:0] e_call(input logic iflag);
    return exp_o(0, 1, 0, 2'd0, 0, 0, 1, 1, 2'd3, 1, 0, 0, iflag);
  endfunction
  function automatic logic [14:0] e_ret(input logic rest, input logic iflag);
    return exp_o(0, 1, 0, 2'd1, 0, 1, 0, 0, 2'd2, 0, 0, rest, iflag);
  endfunction
  function automatic logic [14:0] e_intr();
    return exp_o(0, 1, 0, 2'd2, 0, 0, 1, 1, 2'd3, 1, 1, 0, 1);
  endfunction

  task automatic next_cycle();
    @(posedge CLK);
    #2;
  endtask

  task automatic test_reset();
    logic [14:0] exp;
    RST = 1'b0; INT = 1'b1; OPCODE = CALL;
    repeat (3) next_cycle();
    #1; exp = e_init(); total++;
    if (outs !== exp) begin bad++; $display("FAIL reset_hold got=%h exp=%h", outs, exp); end
    INT = 1'b0; OPCODE = NOP;
    RST = 1'b1;
    #1; total++;
    if (outs !== exp) begin bad++; $display("FAIL reset_init_cycle got=%h exp=%h", outs, exp); end
    next_cycle();
    #1; exp = e_fetch(0); total++;
    if (outs !== exp) begin bad++; $display("FAIL reset_first_fetch got=%h exp=%h", outs, exp); end
    next_cycle();
    #1; exp = e_idle(0); total++;
    if (outs !== exp) begin bad++; $display("FAIL reset_nop_exec got=%h exp=%h", outs, exp); end
    next_cycle();
  endtask

  task automatic test_branches();
    logic [6:0]  ops [6] = '{BREQ, BREQ, BRNE, BRCS, BRCC, BRN};
    logic        zs  [6] = '{1, 0, 0, 0, 0, 0};
    logic        cs  [6] = '{0, 0, 0, 1, 1, 0};
    logic        tk  [6] = '{1, 0, 1, 1, 0, 1};
    logic [14:0] exp;
    for (int i = 0; i < 6; i++) begin
      OPCODE = ops[i]; Z_FLAG = zs[i]; C_FLAG = cs[i];
      #1; exp = e_fetch(0); total++;
      if (outs !== exp) begin bad++; $display("FAIL branch_fetch[%0d] got=%h exp=%h", i, outs, exp); end
      next_cycle();
      #1; exp = tk[i] ? e_br(0) : e_idle(0); total++;
      if (outs !== exp) begin bad++; $display("FAIL branch_exec[%0d] got=%h exp=%h", i, outs, exp); end
      next_cycle();
    end
    Z_FLAG = 1'b0; C_FLAG = 1'b0;
  endtask

  task automatic test_call_ret();
    logic [14:0] exp;
    OPCODE = CALL;
    next_cycle();
    #1; exp = e_call(0); total++;
    if (outs !== exp) begin bad++; $display("FAIL call_exec got=%h exp=%h", outs, exp); end
    next_cycle();
    OPCODE = RET;
    next_cycle();
    #1; exp = e_ret(0, 0); total++;
    if (outs !== exp) begin bad++; $display("FAIL ret_exec got=%h exp=%h", outs, exp); end
    next_cycle();
  endtask

  task automatic test_sei_int();
    logic [14:0] exp;
    OPCODE = SEI; INT = 1'b1;
    next_cycle();
    #1; exp = e_idle(0); total++;
    if (outs !== exp) begin bad++; $display("FAIL sei_exec got=%h exp=%h", outs, exp); end
    next_cycle();
    #1; exp = e_fetch(1); total++;
    if (outs !== exp) begin bad++; $display("FAIL sei_no_intr got=%h exp=%h", outs, exp); end
    OPCODE = NOP;
    next_cycle();
    #1; exp = e_idle(1); total++;
    if (outs !== exp) begin bad++; $display("FAIL after_sei_exec got=%h exp=%h", outs, exp); end
    next_cycle();
    #1; exp = e_intr(); total++;
    if (outs !== exp) begin bad++; $display("FAIL intr_cycle got=%h exp=%h", outs, exp); end
    next_cycle();
    #1; exp = e_fetch(0); total++;
    if (outs !== exp) begin bad++; $display("FAIL intr_to_fetch got=%h exp=%h", outs, exp); end
    next_cycle();
    next_cycle();
    #1; exp = e_fetch(0); total++;
    if (outs !== exp) begin bad++; $display("FAIL int_held_disabled got=%h exp=%h", outs, exp); end
  endtask

  task automatic test_retie_retid();
    logic [14:0] exp;
    OPCODE = RETIE;
    next_cycle();
    #1; exp = e_ret(1, 0); total++;
    if (outs !== exp) begin bad++; $display("FAIL retie_exec got=%h exp=%h", outs, exp); end
    next_cycle();
    #1; exp = e_fetch(1); total++;
    if (outs !== exp) begin bad++; $display("FAIL retie_no_intr got=%h exp=%h", outs, exp); end
    OPCODE = NOP;
    next_cycle();
    next_cycle();
    #1; exp = e_intr(); total++;
    if (outs !== exp) begin bad++; $display("FAIL retie_late_intr got=%h exp=%h", outs, exp); end
    INT = 1'b0;
    next_cycle();
    OPCODE = SEI;
    next_cycle();
    next_cycle();
    OPCODE = RETID;
    next_cycle();
    #1; exp = e_ret(1, 1); total++;
    if (outs !== exp) begin bad++; $display("FAIL retid_exec got=%h exp=%h", outs, exp); end
    next_cycle();
    #1; exp = e_fetch(0); total++;
    if (outs !== exp) begin bad++; $display("FAIL retid_clears got=%h exp=%h", outs, exp); end
    OPCODE = SEI;
    next_cycle();
    next_cycle();
    OPCODE = CLI;
    next_cycle();
    next_cycle();
    #1; exp = e_fetch(0); total++;
    if (outs !== exp) begin bad++; $display("FAIL cli_clears got=%h exp=%h", outs, exp); end
  endtask

  task automatic test_reset_in_intr();
    logic [14:0] exp;
    OPCODE = SEI;
    next_cycle();
    next_cycle();
    OPCODE = NOP; INT = 1'b1;
    next_cycle();
    next_cycle();
    #1; exp = e_intr(); total++;
    if (outs !== exp) begin bad++; $display("FAIL pre_abort_intr got=%h exp=%h", outs, exp); end
    #1; RST = 1'b0;
    #1; exp = e_init(); total++;
    if (outs !== exp) begin bad++; $display("FAIL abort_intr got=%h exp=%h", outs, exp); end
    INT = 1'b0;
    next_cycle();
    RST = 1'b1;
    next_cycle();
    #1; exp = e_fetch(0); total++;
    if (outs !== exp) begin bad++; $display("FAIL abort_recover got=%h exp=%h", outs, exp); end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_branches();
    test_call_ret();
    test_sei_int();
    test_retie_retid();
    test_reset_in_intr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
